ro_select_counter: RTL and testbench

Parametrised successor to the 16:1 ring-oscillator output mux. It selects one of `N_INPUTS` free-running oscillator lines through a registered, glitch-gated select and forwards it to the pad. It also measures the selected oscillator's frequency by counting synchronised rising edges over a programmable window of `wb_clk_i` cycles. The block sits between the oscillator array and the user I/O / logic-analyzer probes, so software can sweep oscillators and read counts without an external frequency counter.

---
 rtl/ro_select_counter.sv | 146 ++++++++++++++
 tb/tb_ro_select_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_select_counter.sv
// Ring-oscillator select mux with glitch-gated pad output and a windowed
// rising-edge frequency counter running entirely in the wb_clk_i domain.
module ro_select_counter #(
    parameter int unsigned N_INPUTS      = 16,
    parameter int unsigned SEL_W         = $clog2(N_INPUTS),
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [N_INPUTS-1:0] osc_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic [WIN_W-1:0]    win_len_i,
    input  logic                start_i,
    output logic                osc_o,
    output logic [SEL_W-1:0]    sel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                overflow_o,
    output logic                err_o
);

    localparam int unsigned ST_W = $clog2(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    state_t            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [WIN_W-1:0]  win_q;
    logic              gate_q;
    logic [ST_W-1:0]   settle_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              done_q;
    logic              err_q;
    logic              busy_q;

    logic osc_mux;
    logic edge_det;
    logic sel_bad;

    assign osc_mux  = osc_i[sel_q];
    assign edge_det = sync2_q & ~sync3_q;
    assign sel_bad  = 32'(sel_i) >= N_INPUTS;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (edge_det) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            win_q      <= '0;
            gate_q     <= 1'b1;
            settle_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q <= osc_mux;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (sel_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            sel_q    <= sel_i;
                            win_q    <= win_len_i;
                            gate_q   <= 1'b0;
                            settle_q <= '0;
                            cnt_q    <= '0;
                            ovf_q    <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_q == ST_W'(SETTLE_CYCLES - 1)) begin
                        gate_q <= 1'b1;
                        if (win_q == '0) begin
                            count_q    <= cnt_q;
                            overflow_q <= ovf_q;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= COUNT;
                        end
                    end else begin
                        settle_q <= settle_q + ST_W'(1);
                    end
                end
                COUNT: begin
                    // win_q doubles as the remaining-cycle counter; the final
                    // cycle's edge is folded in via cnt_d so done_o is not delayed
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_d;
                    if (win_q == WIN_W'(1)) begin
                        count_q    <= cnt_d;
                        overflow_q <= ovf_d;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        win_q <= win_q - WIN_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign osc_o      = osc_mux & gate_q;
    assign sel_o      = sel_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ro_select_counter.sv
// Scoreboard bench for ro_select_counter: stimulus pushes expected pulses,
// a negedge monitor pops and compares on every done_o / err_o.
module tb_ro_select_counter;

    localparam int N    = 12;
    localparam int SW   = 4;
    localparam int CW   = 5;
    localparam int WW   = 16;
    localparam int S    = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  osc;
    logic [SW-1:0] sel = '0;
    logic [WW-1:0] win = '0;
    logic          start = 1'b0;
    logic          osc_o, busy_o, done_o, overflow_o, err_o;
    logic [SW-1:0] sel_o;
    logic [CW-1:0] count_o;

    ro_select_counter #(
        .N_INPUTS(N), .SEL_W(SW), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYCLES(S)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .osc_i(osc), .sel_i(sel),
        .win_len_i(win), .start_i(start), .osc_o(osc_o), .sel_o(sel_o),
        .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .overflow_o(overflow_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Line g toggles every (2 + g%5) clock periods, offset away from clock edges.
    function automatic int half_per(input int g);
        return 2 + (g % 5);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_osc
        logic o = 1'b0;
        initial begin
            #(2 + g * 10);
            forever #(half_per(g) * 10) o = ~o;
        end
        assign osc[g] = o;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int exp_cyc;
        int lo;
        int hi;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    endtask

    // Edges of a period-p square wave in w cycles are floor or ceil of w/p;
    // allow one more either way for synchroniser phase. ok=0 when saturation is ambiguous.
    task automatic model(input int p, input int w, output bit ok,
                         output int lo, output int hi, output bit ovf);
        int fl, ce;
        fl = w / p;
        ce = (w + p - 1) / p;
        ok = 1'b1; ovf = 1'b0;
        if (w == 0) begin
            lo = 0; hi = 0;
        end else begin
            lo = (fl > 0) ? fl - 1 : 0;
            hi = ce + 1;
            if (lo > CMAX) begin
                lo = CMAX; hi = CMAX; ovf = 1'b1;
            end else if (hi > CMAX) begin
                ok = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done_o || err_o)) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b at cycle %0d, expected none",
                         done_o, err_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_err", int'(err_o), int'(e.is_err));
                chk("pulse_done", int'(done_o), int'(!e.is_err));
                chk("pulse_cycle", cyc, e.exp_cyc);
                if (!e.is_err) begin
                    chk_rng("count", int'(count_o), e.lo, e.hi);
                    chk("overflow", int'(overflow_o), int'(e.ovf));
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", int'(busy_o), 0);
    endtask

    task automatic wait_drain(input int lim);
        int t = 0;
        while (sb.size() != 0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input int s, input int w, input bit poke);
        exp_t e;
        bit ok;
        int lo, hi;
        bit ovf;
        logic [SW-1:0] prev_sel;
        wait_idle();
        e.is_err = (s >= N);
        e.lo = 0; e.hi = 0; e.ovf = 1'b0;
        if (e.is_err) begin
            e.exp_cyc = cyc + 1;
        end else begin
            model(2 * half_per(s), w, ok, lo, hi, ovf);
            e.lo = lo; e.hi = hi; e.ovf = ovf;
            e.exp_cyc = cyc + 1 + S + w;
        end
        sb.push_back(e);
        prev_sel = sel_o;
        sel = SW'(s);
        win = WW'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (e.is_err) begin
            chk("err_sel_kept", int'(sel_o), int'(prev_sel));
            chk("err_not_busy", int'(busy_o), 0);
        end else begin
            chk("accept_busy", int'(busy_o), 1);
            chk("settle_gated", int'(osc_o), 0);
            chk("sel_latched", int'(sel_o), s);
            if (poke && w > 3) begin
                repeat (S + 1) @(negedge clk);
                sel = SW'((s + 1) % N);
                win = '0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("ignored_start_sel", int'(sel_o), s);
                chk("ignored_start_busy", int'(busy_o), 1);
            end
        end
        wait_drain(600);
        if (!e.is_err) chk("osc_forward", int'(osc_o), int'(osc[s]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int s, w, lo, hi, tries;
        bit ok, ovf;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sel", int'(sel_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_err", int'(err_o), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_osc_follow", int'(osc_o), int'(osc[0]));
        end

        run(5, 64, 1'b0);
        run(13, 0, 1'b0);
        run(3, 0, 1'b0);
        run(0, 200, 1'b0);
        run(0, 20, 1'b0);
        run(7, 100, 1'b1);

        // Reset ten cycles into COUNT: measurement must vanish without done_o.
        wait_idle();
        sel = 4'd4; win = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_count", int'(count_o), 0);
        chk("midrst_ovf", int'(overflow_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_sel", int'(sel_o), 0);
        chk("midrst_osc", int'(osc_o), int'(osc[0]));
        repeat (150) @(negedge clk);
        run(4, 40, 1'b0);

        for (int i = 0; i < 20; i++) begin
            s = $urandom_range(0, 15);
            w = 0;
            if (s < N) begin
                tries = 0;
                do begin
                    w = $urandom_range(0, 200);
                    model(2 * half_per(s), w, ok, lo, hi, ovf);
                    tries++;
                end while (!ok && tries < 50);
                if (!ok) w = 0;
            end
            run(s, w, $urandom_range(0, 3) == 0);
        end

        wait_drain(600);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
